// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer.
// Walks every RO pair in turn: warm the two selected ROs with the shared
// counters held clear, count for a fixed window, wait for the counter values
// to cross into this clock domain, then record one response bit per pair.
module ro_puf_sequencer #(
   parameter int PAIRS         = 64,
   parameter int RO_COUNT      = 128,
   parameter int WINDOW_CYCLES = 50000,
   parameter int SETTLE_CYCLES = 16,
   parameter int SYNC_CYCLES   = 2,
   parameter int CNT_W         = 32,
   localparam int SEL_W        = $clog2(RO_COUNT),
   localparam int TIE_W        = $clog2(PAIRS + 1)
) (
   input  logic              clk_ref,
   input  logic              rst,
   input  logic              start,
   output logic [SEL_W-1:0]  ro_sel_a,
   output logic [SEL_W-1:0]  ro_sel_b,
   output logic              ro_en,
   output logic              cnt_clr,
   output logic              cnt_en,
   input  logic [CNT_W-1:0]  cnt_a,
   input  logic [CNT_W-1:0]  cnt_b,
   output logic              busy,
   output logic              done,
   output logic              valid,
   output logic [PAIRS-1:0]  puf_response,
   output logic [TIE_W-1:0]  tie_count
);

   // A phase length of zero still occupies one cycle.
   localparam int SETTLE_N = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int WINDOW_N = (WINDOW_CYCLES < 1) ? 1 : WINDOW_CYCLES;
   localparam int SYNC_N   = (SYNC_CYCLES   < 1) ? 1 : SYNC_CYCLES;
   localparam int MAX_SW   = (SETTLE_N > WINDOW_N) ? SETTLE_N : WINDOW_N;
   localparam int MAX_N    = (MAX_SW > SYNC_N) ? MAX_SW : SYNC_N;
   // Timer counts 0..N-1, so it never needs to hold N itself.
   localparam int TIMER_W  = $clog2(MAX_N + 1);
   localparam int PAIR_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_MEASURE,
      S_HOLD,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [PAIR_W-1:0]   pair_idx;
   logic [TIMER_W-1:0]  timer;
   logic                timer_last;
   logic                last_pair;

   // The selected pair stays on the mux from SETTLE through COMPARE.
   assign ro_sel_a  = SEL_W'(pair_idx);
   assign ro_sel_b  = SEL_W'(pair_idx) + SEL_W'(PAIRS);
   assign last_pair = (pair_idx == PAIR_W'(PAIRS - 1));
   assign busy      = (state != S_IDLE);

   // Terminal count of the timed phase currently running.
   always_comb begin
      timer_last = 1'b0;
      case (state)
         S_SETTLE:  timer_last = (timer == TIMER_W'(SETTLE_N - 1));
         S_MEASURE: timer_last = (timer == TIMER_W'(WINDOW_N - 1));
         S_HOLD:    timer_last = (timer == TIMER_W'(SYNC_N - 1));
         default:   timer_last = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk_ref or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state and Moore outputs; clear and count enables are decoded from
   // disjoint states, so they can never overlap.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it
      // unassigned, which would infer a latch.
      state_next = state;
      ro_en      = 1'b0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_next = S_SETTLE;
         end
         S_SETTLE: begin
            ro_en   = 1'b1;
            cnt_clr = 1'b1;
            if (timer_last) state_next = S_MEASURE;
         end
         S_MEASURE: begin
            ro_en  = 1'b1;
            cnt_en = 1'b1;
            if (timer_last) state_next = S_HOLD;
         end
         S_HOLD: begin
            if (timer_last) state_next = S_COMPARE;
         end
         S_COMPARE: begin
            state_next = last_pair ? S_DONE : S_SETTLE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Phase timer, pair index and response capture.
   always_ff @(posedge clk_ref or posedge rst) begin
      if (rst) begin
         pair_idx     <= '0;
         timer        <= '0;
         puf_response <= '0;
         tie_count    <= '0;
         valid        <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  pair_idx     <= '0;
                  timer        <= '0;
                  puf_response <= '0;
                  tie_count    <= '0;
                  valid        <= 1'b0;
               end
            end
            S_SETTLE, S_MEASURE, S_HOLD: begin
               timer <= timer_last ? '0 : timer + 1'b1;
            end
            S_COMPARE: begin
               timer                  <= '0;
               // A tie is not "greater", so it records a 0 here.
               puf_response[pair_idx] <= (cnt_a > cnt_b);
               if (cnt_a == cnt_b) tie_count <= tie_count + 1'b1;
               if (!last_pair) pair_idx <= pair_idx + 1'b1;
            end
            S_DONE: begin
               valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed bench for ro_puf_sequencer with a small configuration:
// 4 pairs, 2-cycle settle, 8-cycle window, 2-cycle sync hold.
module tb_ro_puf_sequencer;

   localparam int PAIRS  = 4;
   localparam int ROS    = 8;
   localparam int WINDOW = 8;
   localparam int SETTLE = 2;
   localparam int SYNC   = 2;
   localparam int CNT_W  = 32;
   localparam int PER    = SETTLE + WINDOW + SYNC + 1;   // 13 cycles per pair
   localparam int TOTAL  = PAIRS * PER + 1;              // done in cycle 53

   logic              clk_ref = 1'b0;
   logic              rst     = 1'b0;
   logic              start   = 1'b0;
   logic [2:0]        ro_sel_a;
   logic [2:0]        ro_sel_b;
   logic              ro_en;
   logic              cnt_clr;
   logic              cnt_en;
   logic [CNT_W-1:0]  cnt_a;
   logic [CNT_W-1:0]  cnt_b;
   logic              busy;
   logic              done;
   logic              valid;
   logic [3:0]        puf_response;
   logic [2:0]        tie_count;

   logic [CNT_W-1:0]  tab_a [PAIRS];
   logic [CNT_W-1:0]  tab_b [PAIRS];

   int tests_run  = 0;
   int fail_count = 0;

   ro_puf_sequencer #(
      .PAIRS         (PAIRS),
      .RO_COUNT      (ROS),
      .WINDOW_CYCLES (WINDOW),
      .SETTLE_CYCLES (SETTLE),
      .SYNC_CYCLES   (SYNC),
      .CNT_W         (CNT_W)
   ) dut (
      .clk_ref      (clk_ref),
      .rst          (rst),
      .start        (start),
      .ro_sel_a     (ro_sel_a),
      .ro_sel_b     (ro_sel_b),
      .ro_en        (ro_en),
      .cnt_clr      (cnt_clr),
      .cnt_en       (cnt_en),
      .cnt_a        (cnt_a),
      .cnt_b        (cnt_b),
      .busy         (busy),
      .done         (done),
      .valid        (valid),
      .puf_response (puf_response),
      .tie_count    (tie_count)
   );

   always #5 clk_ref = ~clk_ref;

   // Counter model: each RO's count depends on which RO the mux selects.
   always_comb begin
      cnt_a = tab_a[ro_sel_a[1:0]];
      cnt_b = tab_b[ro_sel_b[1:0]];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_count++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_table(input int a0, input int a1, input int a2, input int a3,
                            input int b0, input int b1, input int b2, input int b3);
      tab_a[0] = CNT_W'(a0); tab_a[1] = CNT_W'(a1); tab_a[2] = CNT_W'(a2); tab_a[3] = CNT_W'(a3);
      tab_b[0] = CNT_W'(b0); tab_b[1] = CNT_W'(b1); tab_b[2] = CNT_W'(b2); tab_b[3] = CNT_W'(b3);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of cycle 1.
   task automatic start_run();
      start = 1'b1;
      @(negedge clk_ref);
      start = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check(tag,
            64'({busy, done, ro_en, cnt_clr, cnt_en, valid, ro_sel_a, ro_sel_b, puf_response, tie_count}),
            64'({6'b000000, 3'd0, 3'd4, 4'b0000, 3'd0}));
   endtask

   // Called at the negedge of cycle 1 of a run; checks every cycle through
   // DONE, then the held result in the following IDLE cycle.
   task automatic run_cycles(input logic [3:0] exp_resp, input logic [2:0] exp_tie,
                             input bit pokes, input bit hold_start, input string name);
      int   clr_n [PAIRS];
      int   en_n  [PAIRS];
      int   overlap;
      int   pair;
      int   off;
      logic exp_clr;
      logic exp_en;
      overlap = 0;
      for (int p = 0; p < PAIRS; p++) begin
         clr_n[p] = 0;
         en_n[p]  = 0;
      end
      for (int c = 1; c <= TOTAL; c++) begin
         if (c < TOTAL) begin
            pair    = (c - 1) / PER;
            off     = (c - 1) % PER;
            exp_clr = (off < SETTLE);
            exp_en  = (off >= SETTLE) && (off < SETTLE + WINDOW);
            check($sformatf("%s c%0d ctl", name, c),
                  64'({busy, done, cnt_clr, cnt_en, valid, ro_sel_a, ro_sel_b}),
                  64'({1'b1, 1'b0, exp_clr, exp_en, 1'b0, 3'(pair), 3'(pair + PAIRS)}));
            if (off < SETTLE + WINDOW + SYNC)
               check($sformatf("%s c%0d ro_en", name, c), 64'(ro_en), 64'(exp_clr | exp_en));
            clr_n[pair] += int'(cnt_clr);
            en_n[pair]  += int'(cnt_en);
            if (cnt_clr && cnt_en) overlap++;
         end else begin
            check($sformatf("%s c%0d done", name, c),
                  64'({busy, done, cnt_clr, cnt_en}), 64'(4'b1100));
         end
         start = hold_start || (pokes && (c == 5 || c == 30 || c == TOTAL));
         @(negedge clk_ref);
      end
      start = hold_start;
      for (int p = 0; p < PAIRS; p++) begin
         check($sformatf("%s p%0d clr_cycles", name, p), 64'(clr_n[p]), 64'(SETTLE));
         check($sformatf("%s p%0d en_cycles", name, p), 64'(en_n[p]), 64'(WINDOW));
      end
      check($sformatf("%s overlap", name), 64'(overlap), 64'(0));
      check($sformatf("%s idle flags", name), 64'({busy, done, valid}), 64'(3'b001));
      check($sformatf("%s response", name), 64'(puf_response), 64'(exp_resp));
      check($sformatf("%s ties", name), 64'(tie_count), 64'(exp_tie));
   endtask

   initial begin
      set_table(10, 5, 7, 2, 5, 10, 3, 9);

      // Reset acts before any clock edge.
      #1 rst = 1'b1;
      #1 check_reset_outputs("reset async");
      @(negedge clk_ref);
      @(negedge clk_ref);
      rst = 1'b0;
      @(negedge clk_ref);
      check("idle after reset", 64'({busy, done, valid}), 64'(3'b000));

      // Nominal run: 10>5, 5<10, 7>3, 2<9.
      start_run();
      run_cycles(4'b0101, 3'd0, 1'b0, 1'b0, "nominal");

      // All pairs tie.
      set_table(6, 6, 6, 6, 6, 6, 6, 6);
      start_run();
      run_cycles(4'b0000, 3'd4, 1'b0, 1'b0, "tie");

      // Start pulses while busy, including the DONE cycle, are ignored.
      set_table(10, 5, 7, 2, 5, 10, 3, 9);
      start_run();
      run_cycles(4'b0101, 3'd0, 1'b1, 1'b0, "busy_start");
      @(negedge clk_ref);
      check("busy_start stays idle", 64'({busy, valid, puf_response}), 64'({1'b0, 1'b1, 4'b0101}));

      // Reset in cycle 20 of a run.
      start_run();
      repeat (19) @(negedge clk_ref);
      rst = 1'b1;
      #1 check_reset_outputs("midrun reset");
      repeat (3) begin
         @(negedge clk_ref);
         check("no done under reset", 64'({busy, done}), 64'(2'b00));
      end
      rst = 1'b0;

      // Fresh run after reset: 3<4, 9>2, 1==1, 8>0.
      set_table(3, 9, 1, 8, 4, 2, 1, 0);
      start_run();
      run_cycles(4'b1010, 3'd1, 1'b0, 1'b0, "after_reset");

      // Back-to-back with start held high.
      set_table(10, 5, 7, 2, 5, 10, 3, 9);
      start = 1'b1;
      @(negedge clk_ref);
      run_cycles(4'b0101, 3'd0, 1'b0, 1'b1, "b2b_first");
      @(negedge clk_ref);
      check("b2b accept", 64'({busy, valid, cnt_clr, puf_response}), 64'({3'b101, 4'b0000}));
      start = 1'b0;
      set_table(6, 6, 6, 6, 6, 6, 6, 6);
      run_cycles(4'b0000, 3'd4, 1'b0, 1'b0, "b2b_second");

      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/ro_puf_sequencer.md
RO_PUF_SEQUENCER -- requirements
Module: ro_puf_sequencer

Interface
REQ-001 Parameters SHALL be: PAIRS, default 64, number of RO pairs compared; RO_COUNT, default 128, total ROs, equal to 2*PAIRS.
REQ-002 Parameters SHALL also be: WINDOW_CYCLES, default 50000, count-enable window per pair; SETTLE_CYCLES, default 16, RO warm-up with counters cleared; SYNC_CYCLES, default 2, wait for the counter CDC to settle; CNT_W, default 32, count width.
REQ-003 Port clk_ref  in  1  reference clock; the block SHALL use this single clock.
REQ-004 Port rst  in  1  reset; the block SHALL treat it as asynchronous and active-high.
REQ-005 Port start  in  1  request a full response generation.
REQ-006 Port ro_sel_a  out  clog2(RO_COUNT)  mux select for the first RO of the current pair, equal to pair_idx.
REQ-007 Port ro_sel_b  out  clog2(RO_COUNT)  mux select for the second RO, equal to pair_idx+PAIRS.
REQ-008 Ports ro_en, cnt_clr and cnt_en  out  1 each: enable the selected ROs; clear both shared counters; enable both counters.
REQ-009 Ports cnt_a and cnt_b  in  CNT_W each: synchronized counts from the shared counters.
REQ-010 Ports busy and done  out  1 each: busy is high during a run; done is a one-cycle pulse when the response is complete.
REQ-011 Port valid  out  1  puf_response holds a complete result.
REQ-012 Port puf_response  out  PAIRS  response bits; bit p is the result for pair p.
REQ-013 Port tie_count  out  clog2(PAIRS+1)  count of pairs with cnt_a==cnt_b in the last run.

Function
REQ-014 The FSM SHALL have the states IDLE, SETTLE, MEASURE, HOLD, COMPARE and DONE.
REQ-015 In IDLE, start==1 SHALL cause: pair_idx=0, timer=0, puf_response=0, tie_count=0 and valid=0 on that edge, then transition to SETTLE.
REQ-016 SETTLE SHALL drive ro_en=1 and cnt_clr=1 for exactly SETTLE_CYCLES cycles, then go to MEASURE.
REQ-017 MEASURE SHALL drive ro_en=1 and cnt_en=1 for exactly WINDOW_CYCLES cycles, then go to HOLD.
REQ-018 HOLD SHALL drive ro_en=0 and cnt_en=0 for exactly SYNC_CYCLES cycles, then go to COMPARE.
REQ-019 COMPARE SHALL last 1 cycle and perform these steps:
  - write puf_response[pair_idx] = (cnt_a > cnt_b), unsigned compare;
  - on a tie, write bit 0 and increment tie_count;
  - if pair_idx==PAIRS-1, go to DONE;
  - otherwise, increment pair_idx, reset timer and go to SETTLE.
REQ-020 DONE SHALL last 1 cycle with done=1, set valid=1 and return to IDLE.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 ro_sel_a and ro_sel_b SHALL stay stable for the whole SETTLE..COMPARE span of a pair.
REQ-023 The first SETTLE cycle SHALL count as cycle 1; done SHALL assert in cycle PAIRS*(SETTLE_CYCLES+WINDOW_CYCLES+SYNC_CYCLES+1)+1.
REQ-024 start SHALL be ignored whenever busy==1, including in the DONE cycle.
REQ-025 start held high SHALL begin a new run on the first IDLE cycle after DONE.
REQ-026 puf_response, valid and tie_count SHALL hold their values in IDLE until the next accepted start.
REQ-027 The timer SHALL be wide enough for the maximum of SETTLE_CYCLES, WINDOW_CYCLES and SYNC_CYCLES, with no wrap before the terminal count.
REQ-028 A parameter value of 0 SHALL be treated as 1 cycle.
REQ-029 cnt_clr and cnt_en SHALL never be high in the same cycle.

Reset
REQ-030 On rst==1, the block SHALL immediately, without waiting for a clock edge, drive the state to IDLE.
REQ-031 On rst==1, the block SHALL drive pair_idx, timer, puf_response, tie_count, valid, done, busy, ro_en, cnt_clr, cnt_en, ro_sel_a=0 and ro_sel_b=PAIRS to their reset values.
REQ-032 If rst asserts mid-run, the partial response SHALL be discarded and no done pulse SHALL be issued.

Verification
Bench parameters: PAIRS=4, WINDOW_CYCLES=8, SETTLE_CYCLES=2, SYNC_CYCLES=2.
REQ-033 Nominal run: start pulse; model returns cnt_a/cnt_b as 10/5, 5/10, 7/3, 2/9 for pairs 0-3 -> done in cycle 53, puf_response=4'b0101, valid=1, tie_count=0.
REQ-034 Tie: every pair returns 6/6 -> puf_response=0, tie_count=4.
REQ-035 Cycle counts: for each pair, check cnt_clr high for 2 cycles, cnt_en high for 8 cycles, ro_sel_a=p and ro_sel_b=p+4 -> never overlapping, and ro_en low in HOLD.
REQ-036 Busy start: start pulses in cycles 5 and 30 and in the DONE cycle -> ignored, result identical to the nominal run.
REQ-037 Mid-run reset: rst in cycle 20 -> outputs return to reset values asynchronously; no done; a fresh start then completes normally.
REQ-038 Back-to-back: start held high -> a second run begins in the cycle after the IDLE return; valid drops on acceptance and rises at the second done.
